// File: rtl/send_capture_of_verifla.sv
// send_capture_of_verifla
//   Readout stage of the logic analyser. When the monitor requests a dump
//   (sc_run), every capture-memory word from MEM_FIRST_ADDR to MEM_LAST_ADDR
//   is read through RAM port B. Each word is sent as a byte stream, most
//   significant byte first, on a valid/ready interface. When the whole dump
//   has gone out, sc_done is raised and held for the monitor.
//
// Ports
//   clk                 clock
//   rst_l               asynchronous active-low reset
//   sc_run              dump request from the monitor (level, held until ack)
//   ack_sc_run          acknowledge of sc_run
//   sc_done             dump complete (level, cleared by the next request)
//   mem_port_B_address  registered RAM read address
//   mem_port_B_dout     RAM read data (synchronous read, 1-cycle latency)
//   tx_data             byte to transmit
//   tx_valid            tx_data valid
//   tx_ready            sink accepts; transfer when tx_valid && tx_ready
//
// state  | meaning
// IDLE   | waiting for sc_run; sc_done keeps its last value
// ACK    | ack_sc_run high until the monitor drops sc_run
// ADDR   | read address stable, RAM samples it on this edge
// RDWAIT | RAM data valid, captured into the shift register
// LOAD   | first (most significant) byte of the word put on tx_data
// SEND   | byte on the stream; shift per accept, then next word or finish
// DONE   | sc_done raised, back to IDLE next cycle

module send_capture_of_verifla #(
  parameter int MEM_ADDRESS_BITS = 8,
  parameter int MEM_WORDLEN_BITS = 24,
  parameter int MEM_FIRST_ADDR   = 0,
  parameter int MEM_LAST_ADDR    = 255
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        sc_run,
  output logic                        ack_sc_run,
  output logic                        sc_done,
  output logic [MEM_ADDRESS_BITS-1:0] mem_port_B_address,
  input  logic [MEM_WORDLEN_BITS-1:0] mem_port_B_dout,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready
);

  localparam int WORD_BYTES    = (MEM_WORDLEN_BITS + 7) / 8;
  localparam int BYTE_CNT_BITS = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SR_BITS       = WORD_BYTES * 8;

  localparam logic [MEM_ADDRESS_BITS-1:0] FIRST_ADDR = MEM_ADDRESS_BITS'(MEM_FIRST_ADDR);
  localparam logic [MEM_ADDRESS_BITS-1:0] LAST_ADDR  = MEM_ADDRESS_BITS'(MEM_LAST_ADDR);
  localparam logic [BYTE_CNT_BITS-1:0]    CNT_LAST   = BYTE_CNT_BITS'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_ADDR,
    S_RDWAIT,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t                      state, state_nxt;
  logic                        ack_nxt;
  logic                        done_nxt;
  logic                        valid_nxt;
  logic [7:0]                  data_nxt;
  logic [MEM_ADDRESS_BITS-1:0] addr_nxt;
  logic [SR_BITS-1:0]          shift_reg, shift_nxt, shift_adv;
  logic [BYTE_CNT_BITS-1:0]    byte_cnt, cnt_nxt;
  logic                        accept;

  assign accept    = tx_valid && tx_ready;
  // Going through a shifted copy keeps the next-byte slice legal even when a
  // word is a single byte.
  assign shift_adv = shift_reg << 8;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state              <= S_IDLE;
      ack_sc_run         <= 1'b0;
      sc_done            <= 1'b0;
      tx_valid           <= 1'b0;
      tx_data            <= 8'h00;
      mem_port_B_address <= FIRST_ADDR;
      shift_reg          <= '0;
      byte_cnt           <= '0;
    end else begin
      state              <= state_nxt;
      ack_sc_run         <= ack_nxt;
      sc_done            <= done_nxt;
      tx_valid           <= valid_nxt;
      tx_data            <= data_nxt;
      mem_port_B_address <= addr_nxt;
      shift_reg          <= shift_nxt;
      byte_cnt           <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = ack_sc_run;
    done_nxt  = sc_done;
    valid_nxt = tx_valid;
    data_nxt  = tx_data;
    addr_nxt  = mem_port_B_address;
    shift_nxt = shift_reg;
    cnt_nxt   = byte_cnt;

    case (state)
      S_IDLE: begin
        if (sc_run) begin
          // Clearing done together with the ack means the monitor can never
          // see a stale done once it has seen the acknowledge.
          state_nxt = S_ACK;
          ack_nxt   = 1'b1;
          done_nxt  = 1'b0;
          addr_nxt  = FIRST_ADDR;
        end
      end

      S_ACK: begin
        if (!sc_run) begin
          ack_nxt   = 1'b0;
          state_nxt = S_ADDR;
        end
      end

      S_ADDR: begin
        state_nxt = S_RDWAIT;
      end

      S_RDWAIT: begin
        shift_nxt                         = '0;
        shift_nxt[MEM_WORDLEN_BITS-1:0]   = mem_port_B_dout;
        cnt_nxt                           = CNT_LAST;
        state_nxt                         = S_LOAD;
      end

      S_LOAD: begin
        data_nxt  = shift_reg[SR_BITS-1 -: 8];
        valid_nxt = 1'b1;
        state_nxt = S_SEND;
      end

      S_SEND: begin
        if (accept) begin
          if (byte_cnt != '0) begin
            shift_nxt = shift_adv;
            data_nxt  = shift_adv[SR_BITS-1 -: 8];
            cnt_nxt   = byte_cnt - BYTE_CNT_BITS'(1);
          end else if (mem_port_B_address == LAST_ADDR) begin
            // Terminal compare: the address is never advanced past the
            // last word, so an all-ones last address does not wrap.
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            valid_nxt = 1'b0;
            addr_nxt  = mem_port_B_address + MEM_ADDRESS_BITS'(1);
            state_nxt = S_ADDR;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
